// File: rtl/detransrf_b4r5g3.sv
// Word-in / nibble-out group buffer: 3 groups of 5 nibbles.
// Each accepted write fills a whole group. Reads drain the groups one nibble at a time, in write order.
module detransrf_b4r5g3 (
   input  logic        clk_w,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        w_en,
   input  logic [19:0] w_data,
   input  logic        r_en,
   output logic [3:0]  r_data,
   output logic        r_valid,
   output logic        rf_full,
   output logic        rf_empty,
   output logic [1:0]  rf_level
);

   logic [3:0] mem [3][5];
   logic [1:0] occ;
   logic [1:0] w_group;
   logic [1:0] r_group;
   logic [2:0] r_addr;

   logic wr_ok;
   logic rd_ok;
   logic rel;

   assign rf_full  = (occ == 2'd3);
   assign rf_empty = (occ == 2'd0);
   assign rf_level = occ;

   // Full/empty come from the pre-edge count, so a write that coincides with a release while full is still dropped.
   assign wr_ok = w_en & ~rf_full & ~clr;
   assign rd_ok = r_en & ~rf_empty & ~clr;
   assign rel   = rd_ok & (r_addr == 3'd4);

   always_ff @(posedge clk_w or negedge rst_n) begin
      if (!rst_n) begin
         occ     <= '0;
         w_group <= '0;
         r_group <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         for (int unsigned g = 0; g < 3; g++)
            for (int unsigned r = 0; r < 5; r++)
               mem[2'(g)][3'(r)] <= '0;
      end else if (clr) begin
         occ     <= '0;
         w_group <= '0;
         r_group <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         if (wr_ok) begin
            for (int unsigned k = 0; k < 5; k++)
               mem[w_group][3'(k)] <= w_data[19 - 4*k -: 4];
            w_group <= (w_group == 2'd2) ? 2'd0 : w_group + 2'd1;
         end

         r_valid <= rd_ok;
         r_data  <= rd_ok ? mem[r_group][r_addr] : 4'h0;

         if (rd_ok) begin
            if (rel) begin
               r_addr  <= '0;
               r_group <= (r_group == 2'd2) ? 2'd0 : r_group + 2'd1;
            end else begin
               r_addr  <= r_addr + 3'd1;
            end
         end

         if (wr_ok && !rel)
            occ <= occ + 2'd1;
         else if (rel && !wr_ok)
            occ <= occ - 2'd1;
      end
   end

endmodule

// File: tb/tb_detransrf_b4r5g3.sv
// Bench for detransrf_b4r5g3. The reference model is a queue of whole 20-bit words plus an index to the next nibble to read.
// Fixed vectors, hand-built corner sequences and random traffic are all checked against it.
module tb_detransrf_b4r5g3;

   logic        clk_w = 1'b0;
   logic        rst_n;
   logic        clr;
   logic        w_en;
   logic [19:0] w_data;
   logic        r_en;
   logic [3:0]  r_data;
   logic        r_valid;
   logic        rf_full;
   logic        rf_empty;
   logic [1:0]  rf_level;

   int unsigned checks = 0;
   int unsigned errors = 0;

   logic [19:0] mq[$];
   int unsigned ridx = 0;

   detransrf_b4r5g3 dut (
      .clk_w   (clk_w),
      .rst_n   (rst_n),
      .clr     (clr),
      .w_en    (w_en),
      .w_data  (w_data),
      .r_en    (r_en),
      .r_data  (r_data),
      .r_valid (r_valid),
      .rf_full (rf_full),
      .rf_empty(rf_empty),
      .rf_level(rf_level)
   );

   always #5 clk_w = ~clk_w;

   typedef struct {
      logic        c;
      logic        w;
      logic [19:0] d;
      logic        r;
      logic [3:0]  rd;
      logic        v;
      logic [1:0]  lvl;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic c, input logic w, input logic [19:0] d, input logic r,
                               input logic [3:0] rd, input logic v, input logic [1:0] lvl);
      vec_t t;
      t.c = c; t.w = w; t.d = d; t.r = r; t.rd = rd; t.v = v; t.lvl = lvl;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      ridx = 0;
   endtask

   // Drives one cycle of inputs. It checks the flags against the model before the edge, then r_data/r_valid after it.
   task automatic step(input logic c, input logic w, input logic [19:0] d, input logic r);
      int unsigned lvl;
      logic [3:0]  exp_rd;
      logic        exp_v;
      logic [19:0] word;
      lvl    = mq.size();
      exp_rd = 4'h0;
      exp_v  = 1'b0;
      clr = c; w_en = w; w_data = d; r_en = r;
      chk("level", 32'(rf_level), lvl);
      chk("full", 32'(rf_full), 32'(lvl == 3));
      chk("empty", 32'(rf_empty), 32'(lvl == 0));
      if (c) begin
         model_reset();
      end else begin
         if (r && lvl > 0) begin
            word   = mq[0];
            exp_rd = word[19 - 4*ridx -: 4];
            exp_v  = 1'b1;
            ridx++;
            if (ridx == 5) begin
               void'(mq.pop_front());
               ridx = 0;
            end
         end
         if (w && lvl < 3) mq.push_back(d);
      end
      @(posedge clk_w);
      #1;
      chk("r_data", 32'(r_data), 32'(exp_rd));
      chk("r_valid", 32'(r_valid), 32'(exp_v));
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 20'h0, 1'b0);
   endtask

   task automatic rd_n(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 20'h0, 1'b1);
   endtask

   task automatic check_reset_outputs(input string nm);
      chk({nm, "_rdata"}, 32'(r_data), 32'h0);
      chk({nm, "_rvalid"}, 32'(r_valid), 32'h0);
      chk({nm, "_empty"}, 32'(rf_empty), 32'h1);
      chk({nm, "_full"}, 32'(rf_full), 32'h0);
      chk({nm, "_level"}, 32'(rf_level), 32'h0);
   endtask

   task automatic read_0f0f0(input string nm);
      logic [3:0] exp_n [5];
      exp_n = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h0};
      step(1'b0, 1'b1, 20'h0F0F0, 1'b0);
      for (int unsigned i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 20'h0, 1'b1);
         chk(nm, 32'(r_data), 32'(exp_n[i]));
      end
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; w_en = 1'b0; w_data = '0; r_en = 1'b0;
      model_reset();
      repeat (3) @(posedge clk_w);
      #1;
      check_reset_outputs("reset");
      #2 rst_n = 1'b1;
      #1 check_reset_outputs("post_release");
      @(posedge clk_w);
      #1;

      // Basic write/read, a read while empty, then fill to full with a dropped fourth write.
      tbl.push_back(mk(0, 1, 20'h12345, 0, 4'h0, 0, 2'd1));
      for (int unsigned i = 1; i <= 5; i++)
         tbl.push_back(mk(0, 0, 20'h0, 1, 4'(i), 1, (i == 5) ? 2'd0 : 2'd1));
      tbl.push_back(mk(0, 0, 20'h0, 1, 4'h0, 0, 2'd0));
      tbl.push_back(mk(0, 0, 20'h0, 1, 4'h0, 0, 2'd0));
      tbl.push_back(mk(0, 1, 20'hAAAAA, 0, 4'h0, 0, 2'd1));
      tbl.push_back(mk(0, 1, 20'hBBBBB, 0, 4'h0, 0, 2'd2));
      tbl.push_back(mk(0, 1, 20'hCCCCC, 0, 4'h0, 0, 2'd3));
      tbl.push_back(mk(0, 1, 20'hDDDDD, 0, 4'h0, 0, 2'd3));
      for (int unsigned i = 0; i < 15; i++)
         tbl.push_back(mk(0, 0, 20'h0, 1, 4'hA + 4'(i / 5), 1, 2'(2 - i / 5 + ((i % 5 == 4) ? 0 : 1))));
      tbl.push_back(mk(0, 0, 20'h0, 1, 4'h0, 0, 2'd0));

      foreach (tbl[i]) begin
         step(tbl[i].c, tbl[i].w, tbl[i].d, tbl[i].r);
         chk("tbl_rdata", 32'(r_data), 32'(tbl[i].rd));
         chk("tbl_rvalid", 32'(r_valid), 32'(tbl[i].v));
         chk("tbl_level", 32'(rf_level), 32'(tbl[i].lvl));
      end

      // Write and release in the same cycle: dropped while full, accepted at level 2.
      step(0, 1, 20'hAAAAA, 0);
      step(0, 1, 20'hBBBBB, 0);
      step(0, 1, 20'hCCCCC, 0);
      rd_n(4);
      step(0, 1, 20'hEEEEE, 1);
      chk("ovl_full_rdata", 32'(r_data), 32'hA);
      chk("ovl_full_level", 32'(rf_level), 32'd2);
      rd_n(4);
      step(0, 1, 20'hEEEEE, 1);
      chk("ovl_l2_rdata", 32'(r_data), 32'hB);
      chk("ovl_l2_level", 32'(rf_level), 32'd2);
      rd_n(10);
      idle();
      chk("ovl_drained", 32'(rf_empty), 32'h1);

      // Seven words with r_en on every other cycle, so both pointers wrap past group 2.
      begin
         int unsigned sent = 0;
         for (int unsigned i = 0; i < 80; i++) begin
            logic [19:0] d;
            logic        ok;
            d  = 20'($urandom);
            ok = (sent < 7) && (mq.size() < 3);
            step(0, sent < 7, d, i[0]);
            if (ok) sent++;
         end
         idle();
         chk("wrap_sent", sent, 32'd7);
         chk("wrap_empty", 32'(rf_empty), 32'h1);
      end

      // A flush after two of five nibbles have been read.
      step(0, 1, 20'h12345, 0);
      rd_n(2);
      step(1, 1, 20'h55555, 1);
      chk("clr_empty", 32'(rf_empty), 32'h1);
      chk("clr_rvalid", 32'(r_valid), 32'h0);
      read_0f0f0("clr_readback");

      // Asynchronous reset after two of five nibbles have been read.
      step(0, 1, 20'h12345, 0);
      rd_n(2);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async_rst");
      model_reset();
      @(posedge clk_w);
      #1 rst_n = 1'b1;
      read_0f0f0("rst_readback");

      // Random traffic with occasional flushes.
      for (int unsigned i = 0; i < 2000; i++)
         step($urandom_range(49) == 0, $urandom_range(1), 20'($urandom), $urandom_range(9) < 6);
      step(1, 0, 20'h0, 0);
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
